exe_stage: RTL and testbench

- Execute stage of the 5-stage in-order pipeline, sitting between decode and the memory stage.
- Latches the decode bus and computes the ALU result.
- Runs a multi-cycle iterative divider for div/mod instructions.
- Issues the data-SRAM request and hands the EXE_TO_MEM bus downstream with valid/allowin handshaking; exports hazard info to decode.

---
 rtl/exe_stage.sv | 207 ++++++++++++++++++++
 tb/tb_exe_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, optional iterative divider (EXE_DIV_EN), data-SRAM request, EXE->MEM handoff

module exe_stage #(
  parameter int ID_TO_EXE_BUS_WD  = 154,
  parameter int EXE_TO_MEM_BUS_WD = 73
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_to_exe_valid,
  input  logic [ID_TO_EXE_BUS_WD-1:0]  id_to_exe_bus,
  output logic                         exe_allowin,
  input  logic                         mem_allowin,
  output logic                         exe_to_mem_valid,
  output logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
  output logic                         gr_we_exe,
  output logic [4:0]                   dest_exe,
  output logic                         exe_is_load,
  output logic                         data_sram_en,
  output logic [3:0]                   data_sram_we,
  output logic [31:0]                  data_sram_addr,
  output logic [31:0]                  data_sram_wdata
);

  logic                        exe_valid;
  logic                        exe_ready_go;
  logic [ID_TO_EXE_BUS_WD-1:0] id_to_exe_bus_r;

  logic [31:0] exe_pc;
  logic [31:0] exe_src1;
  logic [31:0] exe_src2;
  logic [11:0] exe_alu_op;
  logic [3:0]  exe_div_op;
  logic        exe_load_op;
  logic        exe_mem_we;
  logic        exe_inst_ld_w;
  logic        exe_inst_lu12i_w;
  logic        exe_gr_we;
  logic [4:0]  exe_dest;
  logic [31:0] exe_rkd_value;
  logic [31:0] alu_result;
  logic [31:0] exe_result;

  assign {exe_pc, exe_src1, exe_src2, exe_alu_op, exe_div_op, exe_load_op, exe_mem_we,
          exe_inst_ld_w, exe_inst_lu12i_w, exe_gr_we, exe_dest, exe_rkd_value} = id_to_exe_bus_r;

  assign exe_allowin      = !exe_valid | (exe_ready_go & mem_allowin);
  assign exe_to_mem_valid = exe_valid & exe_ready_go;

  // Stage occupancy: take whatever decode offers whenever the slot is free or draining
  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid <= 1'b0;
    end else if (exe_allowin) begin
      exe_valid <= id_to_exe_valid;
    end
  end

  // Instruction latch: only overwritten by a real incoming instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      id_to_exe_bus_r <= '0;
    end else if (id_to_exe_valid & exe_allowin) begin
      id_to_exe_bus_r <= id_to_exe_bus;
    end
  end

  // ALU: one-hot op select, each lane masked then OR-combined
  logic [4:0]  shamt;
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign shamt    = exe_src2[4:0];
  assign add_res  = exe_src1 + exe_src2;
  assign sub_res  = exe_src1 - exe_src2;
  assign slt_res  = {31'b0, ($signed(exe_src1) < $signed(exe_src2))};
  assign sltu_res = {31'b0, (exe_src1 < exe_src2)};
  assign sll_res  = exe_src1 << shamt;
  assign srl_res  = exe_src1 >> shamt;
  assign sra_res  = 32'($signed(exe_src1) >>> shamt);

  assign alu_result = ({32{exe_alu_op[11]}} & add_res)
                    | ({32{exe_alu_op[10]}} & sub_res)
                    | ({32{exe_alu_op[9]}}  & slt_res)
                    | ({32{exe_alu_op[8]}}  & sltu_res)
                    | ({32{exe_alu_op[7]}}  & (exe_src1 & exe_src2))
                    | ({32{exe_alu_op[6]}}  & ~(exe_src1 | exe_src2))
                    | ({32{exe_alu_op[5]}}  & (exe_src1 | exe_src2))
                    | ({32{exe_alu_op[4]}}  & (exe_src1 ^ exe_src2))
                    | ({32{exe_alu_op[3]}}  & sll_res)
                    | ({32{exe_alu_op[2]}}  & srl_res)
                    | ({32{exe_alu_op[1]}}  & sra_res)
                    | ({32{exe_alu_op[0]}}  & exe_src2);

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  div_state_t  div_state;
  logic [4:0]  div_count;
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dvsr;

  logic        is_div;
  logic        div_signed;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;
  logic [32:0] div_partial;
  logic [32:0] div_diff;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] div_result;

  assign is_div     = |exe_div_op;
  assign div_signed = exe_div_op[3] | exe_div_op[2];
  assign src1_neg   = div_signed & exe_src1[31];
  assign src2_neg   = div_signed & exe_src2[31];
  assign abs_src1   = src1_neg ? -exe_src1 : exe_src1;
  assign abs_src2   = src2_neg ? -exe_src2 : exe_src2;

  // Restoring step: shift next dividend bit into the remainder, try to subtract
  assign div_partial = {div_rem, div_quo[31]};
  assign div_diff    = div_partial - {1'b0, div_dvsr};

  // Divider FSM: IDLE latches magnitudes, BUSY runs 32 steps, DONE holds until MEM takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
      div_count <= 5'd0;
      div_rem   <= 32'd0;
      div_quo   <= 32'd0;
      div_dvsr  <= 32'd0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (exe_valid & is_div) begin
            div_state <= DIV_BUSY;
            div_count <= 5'd0;
            div_rem   <= 32'd0;
            div_quo   <= abs_src1;
            div_dvsr  <= abs_src2;
          end
        end
        DIV_BUSY: begin
          if (!div_diff[32]) begin
            div_rem <= div_diff[31:0];
            div_quo <= {div_quo[30:0], 1'b1};
          end else begin
            div_rem <= div_partial[31:0];
            div_quo <= {div_quo[30:0], 1'b0};
          end
          div_count <= div_count + 5'd1;
          if (div_count == 5'd31) begin
            div_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (mem_allowin) begin
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Zero divisor bypasses sign-fix so the quotient stays all-ones and remainder is the raw dividend
  assign quo_fixed  = (exe_src2 == 32'd0) ? 32'hFFFF_FFFF :
                      ((src1_neg ^ src2_neg) ? -div_quo : div_quo);
  assign rem_fixed  = (exe_src2 == 32'd0) ? exe_src1 :
                      (src1_neg ? -div_rem : div_rem);
  assign div_result = (exe_div_op[3] | exe_div_op[1]) ? quo_fixed : rem_fixed;

  assign exe_ready_go = is_div ? (div_state == DIV_DONE) : 1'b1;
  assign exe_result   = is_div ? div_result : alu_result;
`else
  logic unused_div_op;

  assign unused_div_op = ^exe_div_op;
  assign exe_ready_go  = 1'b1;
  assign exe_result    = alu_result;
`endif

  assign exe_to_mem_bus = {exe_inst_ld_w, exe_inst_lu12i_w, exe_load_op, exe_gr_we,
                           exe_dest, exe_result, exe_pc};

  assign gr_we_exe   = exe_valid & exe_gr_we;
  assign dest_exe    = exe_dest & {5{exe_valid}};
  assign exe_is_load = exe_valid & exe_load_op;

  // Memory request fires only on the advancing cycle, so a stalled store writes once
  assign data_sram_en    = exe_valid & exe_ready_go & mem_allowin & (exe_load_op | exe_mem_we);
  assign data_sram_we    = {4{data_sram_en & exe_mem_we}};
  assign data_sram_addr  = exe_result;
  assign data_sram_wdata = exe_rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage

module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         id_to_exe_valid;
  logic [153:0] id_to_exe_bus;
  logic         exe_allowin;
  logic         mem_allowin;
  logic         exe_to_mem_valid;
  logic [72:0]  exe_to_mem_bus;
  logic         gr_we_exe;
  logic [4:0]   dest_exe;
  logic         exe_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk              (clk),
    .reset            (reset),
    .id_to_exe_valid  (id_to_exe_valid),
    .id_to_exe_bus    (id_to_exe_bus),
    .exe_allowin      (exe_allowin),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .gr_we_exe        (gr_we_exe),
    .dest_exe         (dest_exe),
    .exe_is_load      (exe_is_load),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic        load_op;
    logic        mem_we;
    logic        ld_w;
    logic        lu12i;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rkd;
    logic [31:0] exp;
  } rec_t;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   sram_writes = 0;
  int   stores_sent = 0;
  rec_t q[$];
  rec_t mon_h;
  logic mon_have;
  logic rand_mode = 1'b0;
  logic mem_force = 1'b1;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [153:0] pack(input rec_t r);
    return {r.pc, r.a, r.b, r.alu_op, r.div_op, r.load_op, r.mem_we, r.ld_w, r.lu12i,
            r.gr_we, r.dest, r.rkd};
  endfunction

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                              input logic [11:0] aop, input logic [3:0] dop, input logic ld,
                              input logic we, input logic gr, input logic [4:0] dest,
                              input logic [31:0] rkd, input logic [31:0] exp);
    rec_t r;
    r.pc = pc; r.a = a; r.b = b; r.alu_op = aop; r.div_op = dop;
    r.load_op = ld; r.mem_we = we; r.ld_w = ld; r.lu12i = aop[0];
    r.gr_we = gr; r.dest = dest; r.rkd = rkd; r.exp = exp;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (1'b1)
      op[11]: return a + b;
      op[10]: return a - b;
      op[9]:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      op[8]:  return (a < b) ? 32'd1 : 32'd0;
      op[7]:  return a & b;
      op[6]:  return ~(a | b);
      op[5]:  return a | b;
      op[4]:  return a ^ b;
      op[3]:  return a << b[4:0];
      op[2]:  return a >> b[4:0];
      op[1]:  return sa >>> b[4:0];
      op[0]:  return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] div_ref(input logic [3:0] dop, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (dop[3] | dop[1]) ? 32'hFFFF_FFFF : a;
    if (dop[3] | dop[2]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return dop[3] ? 32'h8000_0000 : 32'd0;
      return dop[3] ? 32'(sa / sb) : 32'(sa % sb);
    end
    return dop[1] ? a / b : a % b;
  endfunction

  // Drive one instruction, hold it until the stage accepts, then record the expectation
  task automatic send(input rec_t r, output int tries);
    logic acc;
    id_to_exe_valid = 1'b1;
    id_to_exe_bus   = pack(r);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 300) begin
      @(negedge clk);
      acc = exe_allowin;
      @(posedge clk);
      tries++;
    end
    if (acc) begin
      q.push_back(r);
      if (r.mem_we) stores_sent++;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted pc=%0h", r.pc);
    end
    #1;
    id_to_exe_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 73'(q.size()), 73'd0);
  endtask

  // Downstream readiness: either forced by the sequence or randomly toggling
  always @(posedge clk) begin
    #2;
    mem_allowin = rand_mode ? 1'($urandom_range(0, 1)) : mem_force;
  end

  // Scoreboard monitor: oldest queued entry is the one sitting in the stage
  always @(negedge clk) begin
    if (!reset) begin
      mon_have = (q.size() > 0);
      mon_h    = mon_have ? q[0] : '0;
      chk("gr_we_exe", 73'(gr_we_exe), 73'(mon_have & mon_h.gr_we));
      chk("dest_exe", 73'(dest_exe), mon_have ? 73'(mon_h.dest) : 73'd0);
      chk("exe_is_load", 73'(exe_is_load), 73'(mon_have & mon_h.load_op));
      if (data_sram_we != 4'd0) sram_writes++;
      if (exe_to_mem_valid) begin
        if (!mon_have) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid actual=1 required=0 at %0t", $time);
        end else begin
          chk("to_mem_bus", exe_to_mem_bus,
              {mon_h.ld_w, mon_h.lu12i, mon_h.load_op, mon_h.gr_we, mon_h.dest, mon_h.exp, mon_h.pc});
          if (mem_allowin) begin
            chk("sram_en", 73'(data_sram_en), 73'(mon_h.load_op | mon_h.mem_we));
            if (mon_h.load_op | mon_h.mem_we) begin
              chk("sram_addr", 73'(data_sram_addr), 73'(mon_h.exp));
              chk("sram_we", 73'(data_sram_we), mon_h.mem_we ? 73'hF : 73'h0);
              chk("sram_wdata", 73'(data_sram_wdata), 73'(mon_h.rkd));
            end
            void'(q.pop_front());
          end
        end
      end
      if (!(exe_to_mem_valid && mem_allowin)) chk("sram_idle", 73'(data_sram_en), 73'd0);
    end
  end

  vec_t vecs[14];

  initial begin
    rec_t r;
    int   tries;
    int   total;
    int   n;
    int   w0;
    logic allow_bad;
    logic [3:0]  dop;
    logic [11:0] aop;
    int   kind;

    vecs[0]  = '{12'h800, 32'd5,         32'd7,         32'd12};
    vecs[1]  = '{12'h800, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[2]  = '{12'h400, 32'd3,         32'd5,         32'hFFFF_FFFE};
    vecs[3]  = '{12'h200, 32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[4]  = '{12'h100, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[5]  = '{12'h080, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[6]  = '{12'h040, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0};
    vecs[7]  = '{12'h020, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[8]  = '{12'h010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[9]  = '{12'h008, 32'd1,         32'h0000_003F, 32'h8000_0000};
    vecs[10] = '{12'h004, 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[11] = '{12'h002, 32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[12] = '{12'h001, 32'd123,       32'hABCD_E000, 32'hABCD_E000};
    vecs[13] = '{12'h200, 32'd5,         32'd3,         32'd0};

    reset = 1'b1;
    id_to_exe_valid = 1'b0;
    id_to_exe_bus = '0;
    mem_allowin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_allowin", 73'(exe_allowin), 73'd1);
    chk("rst_valid", 73'(exe_to_mem_valid), 73'd0);
    chk("rst_gr_we", 73'(gr_we_exe), 73'd0);
    chk("rst_dest", 73'(dest_exe), 73'd0);
    chk("rst_is_load", 73'(exe_is_load), 73'd0);
    chk("rst_sram_en", 73'(data_sram_en), 73'd0);
    chk("rst_sram_we", 73'(data_sram_we), 73'd0);
    @(posedge clk);
    #1;

    r = mk(32'h100, 32'd5, 32'd7, 12'h800, 4'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'd12);
    send(r, tries);
    @(negedge clk);
    chk("add_valid", 73'(exe_to_mem_valid), 73'd1);
    chk("add_result", 73'(exe_to_mem_bus[63:32]), 73'd12);
    chk("add_gr_we", 73'(gr_we_exe), 73'd1);
    chk("add_dest", 73'(dest_exe), 73'd3);
    @(posedge clk);
    #1;

    total = 0;
    for (int i = 0; i < 14; i++) begin
      r = mk(32'h200 + 32'(i * 4), vecs[i].a, vecs[i].b, vecs[i].alu_op, 4'h0, 1'b0, 1'b0,
             1'b1, 5'(i + 1), 32'd0, vecs[i].exp);
      send(r, tries);
      total += tries;
    end
    chk("b2b_one_per_cycle", 73'(total), 73'd14);
    drain();

    mem_force = 1'b0;
    w0 = sram_writes;
    r = mk(32'h300, 32'h1000, 32'd4, 12'h800, 4'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF,
           32'h1004);
    send(r, tries);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("store_stall_en", 73'(data_sram_en), 73'd0);
      @(posedge clk);
    end
    #1;
    mem_force = 1'b1;
    @(negedge clk);
    chk("store_we", 73'(data_sram_we), 73'hF);
    chk("store_addr", 73'(data_sram_addr), 73'h1004);
    chk("store_wdata", 73'(data_sram_wdata), 73'hDEAD_BEEF);
    @(posedge clk);
    #1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("store_once", 73'(sram_writes - w0), 73'd1);

`ifdef EXE_DIV_EN
    r = mk(32'h400, 32'hFFFF_FFF9, 32'd2, 12'h000, 4'h8, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0,
           32'hFFFF_FFFD);
    send(r, tries);
    allow_bad = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (exe_to_mem_valid) break;
      if (exe_allowin) allow_bad = 1'b1;
    end
    chk("div_latency", 73'(n), 73'd34);
    chk("div_allowin_low", 73'(allow_bad), 73'd0);
    @(posedge clk);
    #1;
    r = mk(32'h404, 32'hFFFF_FFF9, 32'd2, 12'h000, 4'h4, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0,
           32'hFFFF_FFFF);
    send(r, tries);
    r = mk(32'h408, 32'd10, 32'd0, 12'h000, 4'h2, 1'b0, 1'b0, 1'b1, 5'd6, 32'd0, 32'hFFFF_FFFF);
    send(r, tries);
    r = mk(32'h40C, 32'd10, 32'd0, 12'h000, 4'h1, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'd10);
    send(r, tries);
    r = mk(32'h410, 32'h8000_0000, 32'hFFFF_FFFF, 12'h000, 4'h8, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0,
           32'h8000_0000);
    send(r, tries);
    drain();

    r = mk(32'h500, 32'd100, 32'd3, 12'h000, 4'h8, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0, 32'd33);
    send(r, tries);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_mid_valid", 73'(exe_to_mem_valid), 73'd0);
    chk("rst_mid_allowin", 73'(exe_allowin), 73'd1);
    @(posedge clk);
    #1;
    send(r, tries);
    drain();
`else
    r = mk(32'h400, 32'd20, 32'd22, 12'h800, 4'h8, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'd42);
    send(r, tries);
    @(negedge clk);
    chk("nodiv_latency", 73'(exe_to_mem_valid), 73'd1);
    @(posedge clk);
    #1;
    drain();
`endif

    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 7));
      aop  = 12'h001 << $urandom_range(0, 11);
      dop  = (kind == 7) ? (4'h1 << $urandom_range(0, 3)) : 4'h0;
      r = mk(32'h1000 + 32'(i * 4), $urandom, (i % 5 == 0) ? 32'd0 : $urandom, aop, dop,
             1'b0, 1'b0, 1'b1, 5'($urandom), $urandom, 32'd0);
      if (kind <= 1) begin
        r.alu_op = 12'h800; r.lu12i = 1'b0; r.load_op = 1'b1; r.ld_w = 1'b1;
      end else if (kind == 2) begin
        r.alu_op = 12'h800; r.lu12i = 1'b0; r.mem_we = 1'b1; r.gr_we = 1'b0;
      end
`ifdef EXE_DIV_EN
      r.exp = (dop != 4'h0) ? div_ref(r.div_op, r.a, r.b) : alu_ref(r.alu_op, r.a, r.b);
`else
      r.exp = alu_ref(r.alu_op, r.a, r.b);
`endif
      send(r, tries);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("final_queue", 73'(q.size()), 73'd0);
    chk("store_count", 73'(sram_writes), 73'(stores_sent));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
